regfile_mp: RTL and testbench

Parametrised multi-read-port integer register file with a built-in scoreboard, the successor to the single-issue 2R1W register file in the RISC-V core. It provides `NUM_RD` combinational read ports and one write port. X0 is hardwired to zero. An optional write-to-read bypass is controlled by a parameter. Per-register pending bits let the decode stage detect read-after-write hazards against in-flight instructions and stall.

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/regfile_mp_scoreboard.sv | 65 ++++++
 rtl/regfile_mp.sv | 137 +++++++++++++
 tb/tb_regfile_mp.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
//
// Shared integer-register definitions for the RISC-V core. The register file
// and the decoder both import this package so that the architectural register
// width, the register address width and the hardwired-zero register address
// are defined in one place.
//
// Contents:
//   XLEN        - architectural integer register width
//   REG_ADDR_W  - register specifier width (x0..x31)
//   xlen_t      - one integer register value
//   reg_addr_t  - one register specifier
//   REG_X0      - address of the hardwired-zero register
// ---------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [XLEN-1:0]       xlen_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  // x0 reads as zero and ignores writes; its address is all zeros.
  localparam reg_addr_t REG_X0 = '0;

endpackage : riscv_pkg

// File: rtl/regfile_mp_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
//
// Per-register pending bits for the multi-port register file. A bit is set
// when an instruction that writes the register issues and cleared when its
// writeback arrives, so decode can detect read-after-write hazards against
// in-flight producers.
//
// Ports:
//   Clk       - clock, state updates on the rising edge
//   Reset     - synchronous, active-low reset; clears every pending bit
//   Flush     - pipeline flush; clears every pending bit
//   IssueEn   - an instruction with a destination register issues
//   IssueAddr - destination register of the issuing instruction
//   WrEn      - writeback valid
//   WrAddr    - writeback destination register
//   Pending   - DEPTH-bit pending vector; bit 0 (x0) is constant zero
// ---------------------------------------------------------------------------
module reg_scoreboard
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Flush,
  input  logic                  IssueEn,
  input  logic [ADDR_WIDTH-1:0] IssueAddr,
  input  logic                  WrEn,
  input  logic [ADDR_WIDTH-1:0] WrAddr,
  output logic [DEPTH-1:0]      Pending
);

  // Only x1..x(DEPTH-1) have a flop; x0 can never be pending.
  logic [DEPTH-1:1] pend_q;

  // Priority per register: reset, flush, issue, writeback, hold.
  // Issue beats a same-cycle writeback to the same register because the
  // newly issued producer supersedes the one that is retiring. Flush beats
  // issue because the issuing instruction is itself being flushed.
  // A writeback to a register that is not pending simply leaves it clear,
  // which covers stale writebacks arriving after a flush.
  // NOTE: sequential state is assigned with non-blocking (<=) so every flop
  // samples the pre-edge values; blocking assignments here would create
  // ordering-dependent simulation and mismatches against synthesis.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      pend_q <= '0;
    end else if (Flush) begin
      pend_q <= '0;
    end else begin
      for (int j = 1; j < DEPTH; j++) begin
        if (IssueEn && (IssueAddr == ADDR_WIDTH'(j))) begin
          pend_q[j] <= 1'b1;
        end else if (WrEn && (WrAddr == ADDR_WIDTH'(j))) begin
          pend_q[j] <= 1'b0;
        end
      end
    end
  end

  assign Pending = {pend_q, 1'b0};

endmodule : reg_scoreboard

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp
//
// Parametrised integer register file with NUM_RD combinational read ports,
// one write port, hardwired-zero x0, optional write-to-read bypass and a
// per-register scoreboard used by decode to stall on read-after-write hazards.
//
// Parameters:
//   ADDR_WIDTH - register address width, depth = 2**ADDR_WIDTH
//   DATA_WIDTH - register width
//   NUM_RD     - number of read ports (1..4)
//   BYPASS     - 1: a same-cycle write is forwarded to the reads and clears
//                the read's busy flag; 0: the write is visible next cycle
//
// Ports:
//   Clk       - clock, state updates on the rising edge
//   Reset     - synchronous, active-low reset
//   RdEn      - per-port read valid, qualifies only Hazard
//   RdAddr    - per-port read address
//   RdData    - per-port read data
//   RdBusy    - per-port: addressed register has a pending write
//   Hazard    - OR over ports of RdEn & RdBusy
//   WrEn      - writeback valid
//   WrAddr    - writeback address
//   WrData    - writeback data
//   IssueEn   - instruction with a destination register issues
//   IssueAddr - destination of the issuing instruction
//   Flush     - clear all pending bits
// ---------------------------------------------------------------------------
module regfile_mp
  import riscv_pkg::*;
#(
  parameter int ADDR_WIDTH = REG_ADDR_W,
  parameter int DATA_WIDTH = XLEN,
  parameter int NUM_RD     = 2,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                                 Clk,
  input  logic                                 Reset,
  input  logic [NUM_RD-1:0]                    RdEn,
  input  logic [NUM_RD-1:0][ADDR_WIDTH-1:0]    RdAddr,
  output logic [NUM_RD-1:0][DATA_WIDTH-1:0]    RdData,
  output logic [NUM_RD-1:0]                    RdBusy,
  output logic                                 Hazard,
  input  logic                                 WrEn,
  input  logic [ADDR_WIDTH-1:0]                WrAddr,
  input  logic [DATA_WIDTH-1:0]                WrData,
  input  logic                                 IssueEn,
  input  logic [ADDR_WIDTH-1:0]                IssueAddr,
  input  logic                                 Flush
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] X0_ADDR = ADDR_WIDTH'(REG_X0);

  // -------------------------------------------------------------------------
  // Data array: x1..x(DEPTH-1) only, x0 is synthesised as a constant.
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] regs_q [1:DEPTH-1];

  // A write presented while Reset is low is discarded because the reset
  // branch has priority.
  // NOTE: this array is deliberately reset: the architectural contract is
  // that every register reads zero after reset. A plain RAM without reset
  // would be cheaper but would expose stale contents after a mid-run reset.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      for (int j = 1; j < DEPTH; j++) begin
        regs_q[j] <= '0;
      end
    end else if (WrEn && (WrAddr != X0_ADDR)) begin
      regs_q[WrAddr] <= WrData;
    end
  end

  // -------------------------------------------------------------------------
  // Scoreboard
  // -------------------------------------------------------------------------
  logic [DEPTH-1:0] pending;

  reg_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_scoreboard (
    .Clk       (Clk),
    .Reset     (Reset),
    .Flush     (Flush),
    .IssueEn   (IssueEn),
    .IssueAddr (IssueAddr),
    .WrEn      (WrEn),
    .WrAddr    (WrAddr),
    .Pending   (pending)
  );

  // -------------------------------------------------------------------------
  // Read ports
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rd_data [NUM_RD];
  logic                  rd_busy [NUM_RD];

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd_port
    logic rd_is_x0;
    logic rd_fwd;

    assign rd_is_x0 = (RdAddr[i] == X0_ADDR);
    // Forwarding is qualified only by the write port, not by Reset, so a
    // write presented during reset is still visible on a matching read.
    assign rd_fwd   = BYPASS && WrEn && (WrAddr == RdAddr[i]);

    // While Reset is low the array still holds pre-reset contents until the
    // edge, so array reads and pending bits are masked to keep the outputs
    // at zero for the whole reset period.
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned; a missing default would infer a latch.
    always_comb begin
      rd_data[i] = '0;
      rd_busy[i] = 1'b0;
      if (rd_is_x0) begin
        rd_data[i] = '0;
        rd_busy[i] = 1'b0;
      end else if (rd_fwd) begin
        rd_data[i] = WrData;
        rd_busy[i] = 1'b0;
      end else if (Reset) begin
        rd_data[i] = regs_q[RdAddr[i]];
        rd_busy[i] = pending[RdAddr[i]];
      end
    end

    assign RdData[i] = rd_data[i];
    assign RdBusy[i] = rd_busy[i];
  end

  // Decode holds the instruction in place while any enabled port is busy.
  assign Hazard = |(RdEn & RdBusy);

endmodule : regfile_mp

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp
//
// Drives two regfile_mp instances (BYPASS=0 and BYPASS=1, four read ports
// each) with identical stimulus. A reference model predicts every output in
// the cycle the stimulus is applied and queues the prediction; a monitor on
// the falling edge pops and compares against both instances.
// ---------------------------------------------------------------------------
module tb_regfile_mp;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int NR = 4;

  typedef struct packed {
    logic [1:0][NR-1:0][DW-1:0] data;  // [bypass][port]
    logic [1:0][NR-1:0]         busy;
    logic [1:0]                 haz;
  } exp_t;

  logic                   clk;
  logic                   reset;
  logic [NR-1:0]          rd_en;
  logic [NR-1:0][AW-1:0]  rd_addr;
  logic                   wr_en;
  logic [AW-1:0]          wr_addr;
  logic [DW-1:0]          wr_data;
  logic                   issue_en;
  logic [AW-1:0]          issue_addr;
  logic                   flush;

  logic [NR-1:0][DW-1:0]  rd_data_nb, rd_data_bp;
  logic [NR-1:0]          rd_busy_nb, rd_busy_bp;
  logic                   hazard_nb,  hazard_bp;

  regfile_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .BYPASS(1'b0)) dut_nb (
    .Clk(clk), .Reset(reset), .RdEn(rd_en), .RdAddr(rd_addr),
    .RdData(rd_data_nb), .RdBusy(rd_busy_nb), .Hazard(hazard_nb),
    .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data),
    .IssueEn(issue_en), .IssueAddr(issue_addr), .Flush(flush)
  );

  regfile_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_RD(NR), .BYPASS(1'b1)) dut_bp (
    .Clk(clk), .Reset(reset), .RdEn(rd_en), .RdAddr(rd_addr),
    .RdData(rd_data_bp), .RdBusy(rd_busy_bp), .Hazard(hazard_bp),
    .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data),
    .IssueEn(issue_en), .IssueAddr(issue_addr), .Flush(flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: architectural register contents and the set of
  // registers with an in-flight producer.
  logic [DW-1:0] m_regs [32];
  bit            m_pend [32];

  exp_t exp_q [$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   stim_done = 0;

  task automatic check(input string name, input int b, input int p,
                       input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s bypass=%0d port=%0d got=%h expected=%h", name, b, p, act, exp);
    end
  endtask

  // Apply one cycle of stimulus, predict the outputs for that cycle, then
  // advance the model to the state after the coming clock edge.
  task automatic apply(input logic rst, input logic we, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic ie, input logic [AW-1:0] ia,
                       input logic fl, input logic [NR-1:0] re,
                       input logic [NR-1:0][AW-1:0] ra);
    exp_t e;
    int   a;
    @(posedge clk);
    #1;
    reset = rst; wr_en = we; wr_addr = wa; wr_data = wd;
    issue_en = ie; issue_addr = ia; flush = fl; rd_en = re; rd_addr = ra;

    e = '0;
    for (int b = 0; b < 2; b++) begin
      for (int p = 0; p < NR; p++) begin
        a = int'(ra[p]);
        if (a == 0) begin
          e.data[b][p] = '0;
          e.busy[b][p] = 1'b0;
        end else if (b == 1 && we && int'(wa) == a) begin
          e.data[b][p] = wd;
          e.busy[b][p] = 1'b0;
        end else if (!rst) begin
          e.data[b][p] = '0;
          e.busy[b][p] = 1'b0;
        end else begin
          e.data[b][p] = m_regs[a];
          e.busy[b][p] = m_pend[a];
        end
      end
      e.haz[b] = |(re & e.busy[b]);
    end
    exp_q.push_back(e);

    if (!rst) begin
      for (int j = 0; j < 32; j++) begin
        m_regs[j] = '0;
        m_pend[j] = 0;
      end
    end else begin
      if (we && wa != 0) m_regs[wa] = wd;
      if (fl) begin
        for (int j = 0; j < 32; j++) m_pend[j] = 0;
      end else begin
        // Retire first, then issue, so a new producer wins over a retiring one.
        if (we) m_pend[wa] = 0;
        if (ie && ia != 0) m_pend[ia] = 1;
      end
    end
  endtask

  function automatic logic [NR-1:0][AW-1:0] all_ports(input logic [AW-1:0] a);
    return {a, a, a, a};
  endfunction

  task automatic idle_read(input logic [NR-1:0] re, input logic [NR-1:0][AW-1:0] ra);
    apply(1'b1, 1'b0, '0, '0, 1'b0, '0, 1'b0, re, ra);
  endtask

  // Monitor: compares every queued prediction against both instances.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        for (int p = 0; p < NR; p++) begin
          check("rd_data", 0, p, rd_data_nb[p], e.data[0][p]);
          check("rd_data", 1, p, rd_data_bp[p], e.data[1][p]);
          check("rd_busy", 0, p, DW'(rd_busy_nb[p]), DW'(e.busy[0][p]));
          check("rd_busy", 1, p, DW'(rd_busy_bp[p]), DW'(e.busy[1][p]));
        end
        check("hazard", 0, 0, DW'(hazard_nb), DW'(e.haz[0]));
        check("hazard", 1, 0, DW'(hazard_bp), DW'(e.haz[1]));
      end
    end
  end

  // Stimulus
  initial begin
    logic [NR-1:0][AW-1:0] ra;
    logic [AW-1:0]         wa, ia;

    reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    issue_en = 1'b0; issue_addr = '0; flush = 1'b0; rd_en = '0; rd_addr = '0;
    for (int j = 0; j < 32; j++) begin
      m_regs[j] = '0;
      m_pend[j] = 0;
    end

    // Write and issue presented during reset are discarded.
    apply(1'b0, 1'b1, 5'd5, 32'hDEAD, 1'b1, 5'd6, 1'b0, 4'hF, all_ports(5'd5));
    apply(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 4'hF, all_ports(5'd5));
    idle_read(4'hF, all_ports(5'd5));
    idle_read(4'hF, all_ports(5'd6));

    // x0: writes dropped, issues ignored.
    apply(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, '0, 1'b0, 4'hF, all_ports(5'd0));
    idle_read(4'hF, all_ports(5'd0));
    apply(1'b1, 1'b0, '0, '0, 1'b1, 5'd0, 1'b0, 4'hF, all_ports(5'd0));
    idle_read(4'hF, all_ports(5'd0));

    // Bypass visibility on port 1.
    apply(1'b1, 1'b1, 5'd7, 32'h1234, 1'b0, '0, 1'b0, 4'h2, {5'd0, 5'd0, 5'd7, 5'd0});
    idle_read(4'h2, {5'd0, 5'd0, 5'd7, 5'd0});

    // RAW hazard on x3 and its clearance by writeback.
    apply(1'b1, 1'b0, '0, '0, 1'b1, 5'd3, 1'b0, 4'h1, {5'd0, 5'd0, 5'd0, 5'd3});
    idle_read(4'h1, {5'd0, 5'd0, 5'd0, 5'd3});
    apply(1'b1, 1'b1, 5'd3, 32'hAA, 1'b0, '0, 1'b0, 4'h1, {5'd0, 5'd0, 5'd0, 5'd3});
    idle_read(4'h1, {5'd0, 5'd0, 5'd0, 5'd3});

    // Issue beats same-cycle writeback; flush beats same-cycle issue.
    apply(1'b1, 1'b1, 5'd9, 32'h99, 1'b1, 5'd9, 1'b0, 4'h3, {5'd0, 5'd0, 5'd4, 5'd9});
    idle_read(4'h3, {5'd0, 5'd0, 5'd4, 5'd9});
    apply(1'b1, 1'b0, '0, '0, 1'b1, 5'd4, 1'b1, 4'h3, {5'd0, 5'd0, 5'd4, 5'd9});
    idle_read(4'hF, {5'd3, 5'd7, 5'd4, 5'd9});
    // Stale writeback after flush updates data only.
    apply(1'b1, 1'b1, 5'd9, 32'h5A5A, 1'b0, '0, 1'b0, 4'h1, {5'd0, 5'd0, 5'd0, 5'd9});
    idle_read(4'h1, {5'd0, 5'd0, 5'd0, 5'd9});

    // Distinct registers on distinct ports, then all ports on one register.
    for (int r = 1; r <= 4; r++) begin
      apply(1'b1, 1'b1, AW'(r), 32'hC0DE_0000 + DW'(r), 1'b0, '0, 1'b0, '0, '0);
    end
    idle_read(4'hF, {5'd4, 5'd3, 5'd2, 5'd1});
    idle_read(4'hF, all_ports(5'd2));

    // Mid-operation reset with pending bits outstanding.
    apply(1'b1, 1'b0, '0, '0, 1'b1, 5'd2, 1'b0, '0, '0);
    apply(1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 4'hF, {5'd4, 5'd3, 5'd2, 5'd1});
    idle_read(4'hF, {5'd4, 5'd3, 5'd2, 5'd1});

    // Randomised traffic concentrated on a few registers to provoke
    // collisions between ports, writes and issues.
    for (int n = 0; n < 800; n++) begin
      for (int p = 0; p < NR; p++) begin
        ra[p] = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
      end
      wa = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
      ia = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(0, 31)) : AW'($urandom_range(0, 7));
      apply(($urandom_range(0, 99) >= 2),
            ($urandom_range(0, 1) == 1), wa, DW'($urandom),
            ($urandom_range(0, 9) < 4), ia,
            ($urandom_range(0, 99) < 5),
            NR'($urandom_range(0, 15)), ra);
    end

    stim_done = 1;
  end

  // Terminate once stimulus is done and the monitor has drained the queue,
  // with an absolute cycle bound as a safety net.
  initial begin
    int cycles;
    cycles = 0;
    while (!stim_done && cycles < 20000) begin
      @(posedge clk);
      cycles++;
    end
    repeat (3) @(posedge clk);
    n_checks++;
    if (!stim_done || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain stim_done=%0d queued=%0d expected done with empty queue",
               stim_done, exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_regfile_mp
